// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU.
// Quotient goes to LO, remainder to HI; one done_o/writeEnable_o=2'b11
// pulse per completed operation drives the HI/LO write port directly.
// Optional feature macro: DIV_ZERO_FAST_EN -- when defined, a zero divisor
// skips the iterations and goes straight from IDLE to DONE.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       writeEnable_o,
  output logic [WIDTH-1:0] HI_data_o,
  output logic [WIDTH-1:0] LO_data_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_rem;      // partial remainder
  logic [WIDTH-1:0] r_quo;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] r_div;      // divisor magnitude
  logic [WIDTH-1:0] r_dvd_raw;  // unmodified dividend, HI result on divide-by-zero
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_signed;
  logic             r_dz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_launch;
  logic             w_div_zero;
  logic             w_fast_dz;
  logic             w_dvd_neg;
  logic             w_dsr_neg;
  logic [WIDTH-1:0] w_dvd_abs;
  logic [WIDTH-1:0] w_dsr_abs;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic [WIDTH-1:0] w_lo_fix;
  logic [WIDTH-1:0] w_hi_fix;

  // Launch qualification: cancel always wins over start.
  assign w_launch   = (r_state == S_IDLE) && start_i && !cancel_i;
  assign w_div_zero = (divisor_i == '0);

`ifdef DIV_ZERO_FAST_EN
  assign w_fast_dz  = w_launch && w_div_zero;
`else
  assign w_fast_dz  = 1'b0;
`endif

  // Operand magnitudes; the sign bit only counts for DIV.
  assign w_dvd_neg = signed_i && dividend_i[WIDTH-1];
  assign w_dsr_neg = signed_i && divisor_i[WIDTH-1];
  assign w_dvd_abs = w_dvd_neg ? (-dividend_i) : dividend_i;
  assign w_dsr_abs = w_dsr_neg ? (-divisor_i)  : divisor_i;

  // Trial subtract one bit wider than the operands so the borrow is the MSB
  // and a remainder with its top bit set is not lost on the shift.
  assign w_trial  = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_div};
  assign w_borrow = w_trial[WIDTH];

  // Sign fix-up and divide-by-zero override applied in FIX.
  assign w_q_fix  = (r_signed && r_q_neg) ? (-r_quo) : r_quo;
  assign w_r_fix  = (r_signed && r_r_neg) ? (-r_rem) : r_rem;
  assign w_lo_fix = r_dz ? '1 : w_q_fix;
  assign w_hi_fix = r_dz ? r_dvd_raw : w_r_fix;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; cancel returns to IDLE from any state.
  always_comb begin
    // NOTE: default assigned first so no path leaves w_next unassigned,
    // which would otherwise infer a latch.
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_fast_dz)     w_next = S_DONE;
        else if (w_launch) w_next = S_BUSY;
      end
      S_BUSY:  if (r_cnt == '1) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (cancel_i) w_next = S_IDLE;
  end

  // Operand capture and one shift/trial-subtract iteration per BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset as well, so a reset mid-operation
    // leaves no stale operand state behind.
    if (rst) begin
      r_cnt     <= '0;
      r_rem     <= '0;
      r_quo     <= '0;
      r_div     <= '0;
      r_dvd_raw <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_signed  <= 1'b0;
      r_dz      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= w_dvd_abs;
            r_div     <= w_dsr_abs;
            r_dvd_raw <= dividend_i;
            r_q_neg   <= w_dvd_neg ^ w_dsr_neg;
            r_r_neg   <= w_dvd_neg;
            r_signed  <= signed_i;
            r_dz      <= w_div_zero;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
          if (!w_borrow) r_rem <= w_trial[WIDTH-1:0];
          else           r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
        end
        default: ;
      endcase
    end
  end

  // Result registers: loaded in FIX (or at launch on the fast zero path) and
  // held otherwise; a cancelled operation never writes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_fast_dz) begin
      r_lo <= '1;
      r_hi <= dividend_i;
    end else if ((r_state == S_FIX) && !cancel_i) begin
      r_lo <= w_lo_fix;
      r_hi <= w_hi_fix;
    end
  end

  assign busy_o        = (r_state != S_IDLE);
  assign done_o        = (r_state == S_DONE);
  assign writeEnable_o = {2{done_o}};
  assign HI_data_o     = r_hi;
  assign LO_data_o     = r_lo;

endmodule
